// File: rtl/thread_state_table.sv
// Per-thread state table answering the scheduler's lookahead reads, fed by a
// CPU and an external write port through a one-entry write stage.
module thread_state_table #(
  parameter int N_THREADS = 16,
  parameter int STATE_W   = 2,
  parameter int TNUM_W    = $clog2(N_THREADS),
  parameter int CNT_W     = $clog2(N_THREADS + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  output logic               init_done,
  input  logic [TNUM_W-1:0]  ts_rd_num,
  output logic [STATE_W-1:0] ts_rd,
  input  logic               cpu_wr_en,
  input  logic [TNUM_W-1:0]  cpu_wr_num,
  input  logic [STATE_W-1:0] cpu_wr_state,
  input  logic               ext_wr_en,
  input  logic [TNUM_W-1:0]  ext_wr_num,
  input  logic [STATE_W-1:0] ext_wr_state,
  output logic               ext_wr_rdy,
  output logic [CNT_W-1:0]   wr_rdy_cnt,
  output logic               err
);

  localparam logic [STATE_W-1:0] ST_NONE   = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_WR_RDY = STATE_W'(1);
  localparam logic [TNUM_W:0]    NUM_LIMIT = (TNUM_W + 1)'(N_THREADS);
  localparam logic [TNUM_W-1:0]  LAST_NUM  = TNUM_W'(N_THREADS - 1);

  typedef enum logic {S_CLEAR, S_RUN} sweep_state_t;

  sweep_state_t       r_state;
  sweep_state_t       w_next_state;
  logic [TNUM_W-1:0]  r_sweep_cnt;
  logic [STATE_W-1:0] r_table [N_THREADS];
  logic               r_stg_vld;
  logic [TNUM_W-1:0]  r_stg_num;
  logic [STATE_W-1:0] r_stg_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_run;
  logic               w_cpu_in_range;
  logic               w_ext_in_range;
  logic               w_rd_in_range;
  logic               w_cpu_acc;
  logic               w_ext_acc;
  logic [STATE_W-1:0] w_old_state;
  logic               w_cnt_inc;
  logic               w_cnt_dec;
  logic               w_double_rdy;
  logic               w_err_set;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_CLEAR: if (r_sweep_cnt == LAST_NUM) w_next_state = S_RUN;
      S_RUN:   w_next_state = S_RUN;
      default: w_next_state = S_CLEAR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_CLEAR;
    else        r_state <= w_next_state;
  end

  assign w_run          = (r_state == S_RUN);
  assign w_cpu_in_range = ({1'b0, cpu_wr_num} < NUM_LIMIT);
  assign w_ext_in_range = ({1'b0, ext_wr_num} < NUM_LIMIT);
  assign w_rd_in_range  = ({1'b0, ts_rd_num} < NUM_LIMIT);

  // CPU always wins; the external port only sees ready when the CPU is idle.
  assign ext_wr_rdy = w_run & ~cpu_wr_en;
  assign w_cpu_acc  = w_run & cpu_wr_en & w_cpu_in_range;
  assign w_ext_acc  = ext_wr_en & ext_wr_rdy & w_ext_in_range;

  assign w_old_state  = r_table[r_stg_num];
  assign w_cnt_inc    = (w_old_state != ST_WR_RDY) && (r_stg_state == ST_WR_RDY);
  assign w_cnt_dec    = (w_old_state == ST_WR_RDY) && (r_stg_state != ST_WR_RDY);
  assign w_double_rdy = r_stg_vld && (w_old_state == ST_WR_RDY) && (r_stg_state == ST_WR_RDY);
  assign w_err_set    = (cpu_wr_en & ~w_run)
                      | (cpu_wr_en & w_run & ~w_cpu_in_range)
                      | (ext_wr_en & ext_wr_rdy & ~w_ext_in_range)
                      | w_double_rdy;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_sweep_cnt <= '0;
    end else if (!w_run && (r_sweep_cnt != LAST_NUM)) begin
      r_sweep_cnt <= r_sweep_cnt + TNUM_W'(1);
    end
  end

  // Memory has no reset of its own; the sweep clears it after every reset.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      if (!w_run) begin
        r_table[r_sweep_cnt] <= ST_NONE;
      end else if (r_stg_vld) begin
        r_table[r_stg_num] <= r_stg_state;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_stg_vld   <= 1'b0;
      r_stg_num   <= '0;
      r_stg_state <= ST_NONE;
    end else begin
      r_stg_vld <= w_cpu_acc | w_ext_acc;
      if (w_cpu_acc) begin
        r_stg_num   <= cpu_wr_num;
        r_stg_state <= cpu_wr_state;
      end else if (w_ext_acc) begin
        r_stg_num   <= ext_wr_num;
        r_stg_state <= ext_wr_state;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (!w_run) begin
      r_cnt <= '0;
    end else if (r_stg_vld) begin
      if (w_cnt_inc)      r_cnt <= r_cnt + CNT_W'(1);
      else if (w_cnt_dec) r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)         r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  // No bypass: a committing write becomes visible the cycle after its commit.
  assign ts_rd      = (w_run && w_rd_in_range) ? r_table[ts_rd_num] : ST_NONE;
  assign init_done  = w_run;
  assign wr_rdy_cnt = r_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_thread_state_table.sv
// Directed bench for thread_state_table: sweep timing, write latency, port
// priority, ready counting and the sticky error flag.
module tb_thread_state_table;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       init_done;
  logic [3:0] ts_rd_num = '0;
  logic [1:0] ts_rd;
  logic       cpu_wr_en = 1'b0;
  logic [3:0] cpu_wr_num = '0;
  logic [1:0] cpu_wr_state = '0;
  logic       ext_wr_en = 1'b0;
  logic [3:0] ext_wr_num = '0;
  logic [1:0] ext_wr_state = '0;
  logic       ext_wr_rdy;
  logic [4:0] wr_rdy_cnt;
  logic       err;

  int total = 0;
  int bad = 0;
  int initCycles;

  thread_state_table #(.N_THREADS(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .init_done(init_done),
    .ts_rd_num(ts_rd_num), .ts_rd(ts_rd),
    .cpu_wr_en(cpu_wr_en), .cpu_wr_num(cpu_wr_num), .cpu_wr_state(cpu_wr_state),
    .ext_wr_en(ext_wr_en), .ext_wr_num(ext_wr_num), .ext_wr_state(ext_wr_state),
    .ext_wr_rdy(ext_wr_rdy), .wr_rdy_cnt(wr_rdy_cnt), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cEn, input logic [3:0] cNum, input logic [1:0] cSt,
                               input logic eEn, input logic [3:0] eNum, input logic [1:0] eSt);
    cpu_wr_en = cEn; cpu_wr_num = cNum; cpu_wr_state = cSt;
    ext_wr_en = eEn; ext_wr_num = eNum; ext_wr_state = eSt;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Counts edges until init_done, bounded; clears write inputs after the first edge.
  task automatic waitInit(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      if (init_done) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0);
    RST_N = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
    waitInit(initCycles);
    checkOutput("init_lat_first", initCycles, 16);

    // Fill the table with garbage: thread i gets (i%3)+1, six of them WR_RDY.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 4'(i), 2'((i % 3) + 1), 0, 0, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    ts_rd_num = 4'd15; #1;
    checkOutput("garbage_rd15", ts_rd, 1);
    ts_rd_num = 4'd14; #1;
    checkOutput("garbage_rd14", ts_rd, 3);
    checkOutput("garbage_cnt", wr_rdy_cnt, 6);

    // Reset over garbage: reads must be NONE during and after the sweep.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    ts_rd_num = 4'd15;
    applyStimulus(0, 0, 0, 1, 4'd1, 2'd2);
    #1;
    checkOutput("clear_rd_none", ts_rd, 0);
    checkOutput("clear_ext_rdy", ext_wr_rdy, 0);
    checkOutput("clear_init", init_done, 0);
    waitInit(initCycles);
    checkOutput("init_lat_reset", initCycles, 16);
    for (int i = 0; i < 16; i++) begin
      ts_rd_num = 4'(i); #1;
      checkOutput($sformatf("sweep_rd%0d", i), ts_rd, 0);
    end
    checkOutput("sweep_cnt", wr_rdy_cnt, 0);
    checkOutput("sweep_err", err, 0);

    // CPU write thread 5 = WR_RDY: visible two cycles later.
    ts_rd_num = 4'd5;
    applyStimulus(1, 4'd5, 2'd1, 0, 0, 0);
    #1;
    checkOutput("w5_rd_t0", ts_rd, 0);
    checkOutput("w5_cnt_t0", wr_rdy_cnt, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("w5_rd_t1", ts_rd, 0);
    checkOutput("w5_cnt_t1", wr_rdy_cnt, 0);
    tick();
    checkOutput("w5_rd_t2", ts_rd, 1);
    checkOutput("w5_cnt_t2", wr_rdy_cnt, 1);

    // Same-cycle conflict: CPU thread 3 BUSY beats external thread 4 WR_RDY.
    applyStimulus(1, 4'd3, 2'd3, 1, 4'd4, 2'd1);
    #1;
    checkOutput("conf_ext_rdy0", ext_wr_rdy, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 4'd4, 2'd1);
    #1;
    checkOutput("conf_ext_rdy1", ext_wr_rdy, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    ts_rd_num = 4'd4; #1;
    checkOutput("conf_rd4_t2", ts_rd, 0);
    ts_rd_num = 4'd3; #1;
    checkOutput("conf_rd3_t2", ts_rd, 3);
    tick();
    ts_rd_num = 4'd4; #1;
    checkOutput("conf_rd4_t3", ts_rd, 1);
    checkOutput("conf_cnt", wr_rdy_cnt, 2);

    // Back-to-back writes to thread 7.
    ts_rd_num = 4'd7;
    applyStimulus(1, 4'd7, 2'd1, 0, 0, 0);
    tick();
    applyStimulus(1, 4'd7, 2'd3, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("b2b_rd_t2", ts_rd, 1);
    checkOutput("b2b_cnt_t2", wr_rdy_cnt, 3);
    tick();
    checkOutput("b2b_rd_t3", ts_rd, 3);
    checkOutput("b2b_cnt_t3", wr_rdy_cnt, 2);
    checkOutput("b2b_err", err, 0);

    // External port releases thread 5.
    applyStimulus(0, 0, 0, 1, 4'd5, 2'd0);
    #1;
    checkOutput("ext5_rdy", ext_wr_rdy, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    ts_rd_num = 4'd5; #1;
    checkOutput("ext5_rd", ts_rd, 0);
    checkOutput("ext5_cnt", wr_rdy_cnt, 1);

    // Double ready on thread 2.
    applyStimulus(1, 4'd2, 2'd1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("dbl_cnt_first", wr_rdy_cnt, 2);
    applyStimulus(1, 4'd2, 2'd1, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("dbl_err_pre", err, 0);
    tick();
    checkOutput("dbl_err_set", err, 1);
    checkOutput("dbl_cnt", wr_rdy_cnt, 2);
    tick();
    tick();
    checkOutput("dbl_err_sticky", err, 1);

    // Reset, then pulse reset again when the sweep reaches entry 9.
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    repeat (9) tick();
    checkOutput("mid_init_pre", init_done, 0);
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    #1;
    checkOutput("mid_err_rst", err, 0);
    applyStimulus(1, 4'd6, 2'd1, 1, 4'd8, 2'd1);
    #1;
    checkOutput("mid_ext_rdy", ext_wr_rdy, 0);
    waitInit(initCycles);
    checkOutput("mid_init_lat", initCycles, 16);
    checkOutput("mid_err_cpu", err, 1);
    checkOutput("mid_cnt", wr_rdy_cnt, 0);
    ts_rd_num = 4'd6; #1;
    checkOutput("mid_rd6", ts_rd, 0);
    ts_rd_num = 4'd2; #1;
    checkOutput("mid_rd2", ts_rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/thread_state_table.md
Name: thread_state_table

Overview:
- Per-thread state store: the responder side of the scheduler's thread-state lookahead interface.
- The scheduler drives ts_rd_num and samples ts_rd in the same cycle.
- Two write ports change thread states:
  - CPU port: e.g. thread releases its slot.
  - External port: e.g. loader/unloader marks a thread WR_RDY or NONE.
- Also maintains a live count of WR_RDY threads and a sticky error flag.

Parameters:
- N_THREADS, 16, number of threads; entries 0..N_THREADS-1.
- STATE_W, 2, state width. Encoding: 0=NONE, 1=WR_RDY, 2=RD_RDY, 3=BUSY.
- TNUM_W, MSB(N_THREADS-1)+1, thread number width.
- CNT_W, MSB(N_THREADS)+1, WR_RDY counter width.

Ports:
- CLK, in, 1, clock; all logic on rising edge.
- RST_N, in, 1, synchronous active-low reset.
- init_done, out, 1, high once the clear sweep has finished.
- ts_rd_num, in, TNUM_W, scheduler read address.
- ts_rd, out, STATE_W, state of ts_rd_num; combinational, no register.
- cpu_wr_en, in, 1, CPU write strobe; always accepted when init_done=1.
- cpu_wr_num, in, TNUM_W, CPU write thread.
- cpu_wr_state, in, STATE_W, CPU new state.
- ext_wr_en, in, 1, external write request.
- ext_wr_num, in, TNUM_W, external write thread.
- ext_wr_state, in, STATE_W, external new state.
- ext_wr_rdy, out, 1, external write accepted this cycle when high together with ext_wr_en.
- wr_rdy_cnt, out, CNT_W, number of entries currently WR_RDY.
- err, out, 1, sticky error flag.

Behaviour:
- Reset (RST_N=0 at an edge):
  - init_done<=0, sweep counter<=0, wr_rdy_cnt<=0, err<=0, pending write stage cleared.
  - Reset mid-operation or mid-sweep restarts the sweep from entry 0.
- Sweep state machine, states CLEAR -> RUN:
  - CLEAR writes NONE to entry sweep_cnt, one entry per cycle, for N_THREADS cycles.
  - After the cycle writing entry N_THREADS-1: init_done<=1, state RUN.
  - During CLEAR:
    - ts_rd returns NONE regardless of table content.
    - ext_wr_rdy=0.
    - cpu_wr_en=1 is dropped and sets err.
- Write acceptance in RUN, at most one write per cycle:
  - CPU has priority.
  - ext_wr_rdy = init_done & ~cpu_wr_en (combinational).
  - Accepted request (num, state) is latched into a 1-entry write stage at edge t.
- Commit and read latency:
  - Write stage commits to the table at edge t+1.
  - ts_rd reflects the new value from cycle t+2: exactly 2 cycles of propagation, which the scheduler relies on.
- Ordering:
  - Writes commit in acceptance order.
  - Back-to-back writes to the same thread: the later one wins; no write is lost.
- Read-during-commit: ts_rd returns the old value in the commit cycle (no bypass).
- wr_rdy_cnt updates at the commit edge. Compare old entry (second async read at write-stage address) with new state:
  - old!=WR_RDY and new==WR_RDY: +1.
  - old==WR_RDY and new!=WR_RDY: -1.
  - Otherwise unchanged; same-state rewrite is no change.
  - Range 0..N_THREADS, cannot over- or underflow by construction.
  - The sweep forces the count to 0.
- err (sticky until reset) is set when either:
  - a CPU write arrives during CLEAR, or
  - a committed write has old==new and new==WR_RDY (double ready, scheduler protocol violation).
- Thread numbers >= N_THREADS (N_THREADS not a power of 2):
  - The write is dropped at acceptance and sets err.
  - Reads return NONE.

Test Plan:
- Reset, N_THREADS=16: table pre-filled with garbage. Required:
  - init_done rises exactly 16 cycles after RST_N deasserts.
  - All 16 reads return NONE.
  - wr_rdy_cnt=0, err=0.
- CPU write thread 5 = WR_RDY at cycle t, ts_rd_num=5 held. Required:
  - ts_rd=NONE at t and t+1, WR_RDY at t+2.
  - wr_rdy_cnt 0->1 at edge t+1.
- Same-cycle conflict: cpu_wr_en (thr 3, BUSY) and ext_wr_en (thr 4, WR_RDY). Required:
  - ext_wr_rdy=0 that cycle.
  - ext accepted the next cycle with inputs held.
  - Final states 3=BUSY, 4=WR_RDY, 4 visible 3 cycles after the first request.
- Back-to-back writes thread 7: WR_RDY at t, BUSY at t+1. Required:
  - ts_rd(7)=WR_RDY at t+2, BUSY at t+3.
  - wr_rdy_cnt 0->1->0.
  - err=0.
- Double ready: thread 2 written WR_RDY twice, non-consecutively. Required:
  - err=1 after the second commit and stays 1.
  - wr_rdy_cnt stays 1.
- RST_N pulsed low for 1 cycle at sweep entry 9. Required:
  - Sweep restarts at entry 0.
  - init_done rises 16 cycles after RST_N returns high.
  - CPU write during the sweep sets err; ext_wr_rdy stays 0.
